// File: rtl/arf.sv
// Architectural register file with rename alias table. It commits ROB retirements,
// tracks the in-flight producer of each register, and answers dispatch source lookups.
module arf #(
  parameter int N_ARF_REGS     = 32,
  parameter int REG_DATA_WIDTH = 32,
  parameter int ROB_ID_WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst_aL,
  input  logic                      retire,
  input  logic [ROB_ID_WIDTH-1:0]   retire_rob_id,
  input  logic [4:0]                retire_arf_id,
  input  logic [REG_DATA_WIDTH-1:0] retire_reg_data,
  input  logic                      dispatch_fire,
  input  logic                      dispatch_dst_valid,
  input  logic [4:0]                dispatch_dst_arf_id,
  input  logic [ROB_ID_WIDTH-1:0]   dispatch_rob_id,
  input  logic [4:0]                src1_arf_id,
  input  logic [4:0]                src2_arf_id,
  output logic                      src1_renamed,
  output logic [ROB_ID_WIDTH-1:0]   src1_rob_id,
  output logic [REG_DATA_WIDTH-1:0] src1_reg_data,
  output logic                      src2_renamed,
  output logic [ROB_ID_WIDTH-1:0]   src2_rob_id,
  output logic [REG_DATA_WIDTH-1:0] src2_reg_data,
  input  logic                      flush
);

  typedef struct packed {
    logic                      renamed;
    logic [ROB_ID_WIDTH-1:0]   rob_id;
    logic [REG_DATA_WIDTH-1:0] data;
  } lookup_t;

  logic [REG_DATA_WIDTH-1:0] r_data    [N_ARF_REGS];
  logic [ROB_ID_WIDTH-1:0]   r_rat_tag [N_ARF_REGS];
  logic [N_ARF_REGS-1:0]     r_rat_valid;

  logic    w_rename;
  logic    w_retire;
  lookup_t w_src1;
  lookup_t w_src2;

  assign w_rename = dispatch_fire & dispatch_dst_valid & (dispatch_dst_arf_id != 5'd0);
  assign w_retire = retire & (retire_arf_id != 5'd0);

  // Entry 0 is x0: never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      r_rat_valid <= '0;
      for (int i = 0; i < N_ARF_REGS; i++) begin
        r_data[i]    <= '0;
        r_rat_tag[i] <= '0;
      end
    end else begin
      for (int i = 1; i < N_ARF_REGS; i++) begin
        if (w_retire && (retire_arf_id == 5'(i)))
          r_data[i] <= retire_reg_data;
        if (flush) begin
          r_rat_valid[i] <= 1'b0;
        end else if (w_rename && (dispatch_dst_arf_id == 5'(i))) begin
          r_rat_valid[i] <= 1'b1;
          r_rat_tag[i]   <= dispatch_rob_id;
        end else if (w_retire && (retire_arf_id == 5'(i)) && r_rat_valid[i] &&
                     (r_rat_tag[i] == retire_rob_id)) begin
          r_rat_valid[i] <= 1'b0;
        end
      end
    end
  end

  // A retire of the current producer forwards its value in the same cycle.
  function automatic lookup_t f_lookup(input logic [4:0] id);
    lookup_t res;
    res = '0;
    if (id != 5'd0) begin
      if (w_retire && (retire_arf_id == id) && r_rat_valid[id] &&
          (r_rat_tag[id] == retire_rob_id)) begin
        res.data = retire_reg_data;
      end else if (r_rat_valid[id]) begin
        res.renamed = 1'b1;
        res.rob_id  = r_rat_tag[id];
      end else begin
        res.data = r_data[id];
      end
    end
    return res;
  endfunction

  always_comb begin
    w_src1 = f_lookup(src1_arf_id);
    w_src2 = f_lookup(src2_arf_id);
  end

  assign src1_renamed  = w_src1.renamed;
  assign src1_rob_id   = w_src1.rob_id;
  assign src1_reg_data = w_src1.data;
  assign src2_renamed  = w_src2.renamed;
  assign src2_rob_id   = w_src2.rob_id;
  assign src2_reg_data = w_src2.data;

endmodule

// File: tb/tb_arf.sv
// Bench for arf: directed scenarios with constant expectations, then random traffic
// checked against an array-based model of committed values and pending producers.
module tb_arf;

  logic        clk = 1'b0;
  logic        rst_aL;
  logic        retire;
  logic [3:0]  retire_rob_id;
  logic [4:0]  retire_arf_id;
  logic [31:0] retire_reg_data;
  logic        dispatch_fire;
  logic        dispatch_dst_valid;
  logic [4:0]  dispatch_dst_arf_id;
  logic [3:0]  dispatch_rob_id;
  logic [4:0]  src1_arf_id;
  logic [4:0]  src2_arf_id;
  logic        src1_renamed;
  logic [3:0]  src1_rob_id;
  logic [31:0] src1_reg_data;
  logic        src2_renamed;
  logic [3:0]  src2_rob_id;
  logic [31:0] src2_reg_data;
  logic        flush;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_data [32];
  bit          m_busy [32];
  logic [3:0]  m_tag  [32];

  arf dut (
    .clk(clk), .rst_aL(rst_aL),
    .retire(retire), .retire_rob_id(retire_rob_id), .retire_arf_id(retire_arf_id),
    .retire_reg_data(retire_reg_data),
    .dispatch_fire(dispatch_fire), .dispatch_dst_valid(dispatch_dst_valid),
    .dispatch_dst_arf_id(dispatch_dst_arf_id), .dispatch_rob_id(dispatch_rob_id),
    .src1_arf_id(src1_arf_id), .src2_arf_id(src2_arf_id),
    .src1_renamed(src1_renamed), .src1_rob_id(src1_rob_id), .src1_reg_data(src1_reg_data),
    .src2_renamed(src2_renamed), .src2_rob_id(src2_rob_id), .src2_reg_data(src2_reg_data),
    .flush(flush)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_data[i] = '0;
      m_busy[i] = 1'b0;
      m_tag[i]  = '0;
    end
  endtask

  // What one clock edge does to the architectural state, given current inputs.
  task automatic model_edge();
    logic [4:0] r, d;
    r = retire_arf_id;
    d = dispatch_dst_arf_id;
    if (retire && r != 0) begin
      m_data[r] = retire_reg_data;
      if (m_busy[r] && m_tag[r] == retire_rob_id) m_busy[r] = 1'b0;
    end
    if (dispatch_fire && dispatch_dst_valid && d != 0) begin
      m_busy[d] = 1'b1;
      m_tag[d]  = dispatch_rob_id;
    end
    if (flush)
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
  endtask

  // Expected {renamed, rob_id, data} for a source given current state and inputs.
  function automatic logic [36:0] m_lookup(input logic [4:0] id);
    if (id == 0) return '0;
    if (retire && retire_arf_id == id && m_busy[id] && m_tag[id] == retire_rob_id)
      return {1'b0, 4'd0, retire_reg_data};
    if (m_busy[id]) return {1'b1, m_tag[id], 32'd0};
    return {1'b0, 4'd0, m_data[id]};
  endfunction

  task automatic idle();
    retire = 0; retire_rob_id = 0; retire_arf_id = 0; retire_reg_data = 0;
    dispatch_fire = 0; dispatch_dst_valid = 0; dispatch_dst_arf_id = 0; dispatch_rob_id = 0;
    flush = 0;
  endtask

  task automatic tick();
    if (rst_aL) model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_dispatch(input logic [4:0] dst, input logic [3:0] rob);
    dispatch_fire = 1; dispatch_dst_valid = 1; dispatch_dst_arf_id = dst; dispatch_rob_id = rob;
  endtask

  task automatic do_retire(input logic [4:0] dst, input logic [3:0] rob, input logic [31:0] val);
    retire = 1; retire_arf_id = dst; retire_rob_id = rob; retire_reg_data = val;
  endtask

  task automatic test_reset();
    idle();
    rst_aL = 0; src1_arf_id = 5'd3; src2_arf_id = 5'd0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_aL = 1;
    #1;
    n_checks++;
    if ({src1_renamed, src1_rob_id, src1_reg_data} !== 37'd0) begin
      n_fail++; $display("FAIL reset_x3 got %h want 0", {src1_renamed, src1_rob_id, src1_reg_data});
    end
    n_checks++;
    if ({src2_renamed, src2_rob_id, src2_reg_data} !== 37'd0) begin
      n_fail++; $display("FAIL reset_x0 got %h want 0", {src2_renamed, src2_rob_id, src2_reg_data});
    end
    do_retire(5'd0, 4'd0, 32'hDEAD);
    do_dispatch(5'd0, 4'd3);
    tick(); idle();
    src1_arf_id = 5'd0; #1;
    n_checks++;
    if ({src1_renamed, src1_rob_id, src1_reg_data} !== 37'd0) begin
      n_fail++; $display("FAIL x0_write_ignored got %h want 0", {src1_renamed, src1_rob_id, src1_reg_data});
    end
  endtask

  task automatic test_rename_bypass();
    do_dispatch(5'd5, 4'd7);
    tick(); idle();
    src1_arf_id = 5'd5; #1;
    n_checks++;
    if (src1_renamed !== 1'b1 || src1_rob_id !== 4'd7 || src1_reg_data !== 32'd0) begin
      n_fail++; $display("FAIL rename_x5 got r=%0b id=%0d d=%h want r=1 id=7 d=0", src1_renamed, src1_rob_id, src1_reg_data);
    end
    do_retire(5'd5, 4'd7, 32'h1234); #1;
    n_checks++;
    if (src1_renamed !== 1'b0 || src1_rob_id !== 4'd0 || src1_reg_data !== 32'h1234) begin
      n_fail++; $display("FAIL bypass_x5 got r=%0b id=%0d d=%h want r=0 id=0 d=1234", src1_renamed, src1_rob_id, src1_reg_data);
    end
    tick(); idle(); #1;
    n_checks++;
    if (src1_renamed !== 1'b0 || src1_reg_data !== 32'h1234) begin
      n_fail++; $display("FAIL commit_x5 got r=%0b d=%h want r=0 d=1234", src1_renamed, src1_reg_data);
    end
  endtask

  task automatic test_younger_survives();
    do_dispatch(5'd6, 4'd2); tick();
    do_dispatch(5'd6, 4'd9); tick(); idle();
    src1_arf_id = 5'd6;
    do_retire(5'd6, 4'd2, 32'hAA); #1;
    n_checks++;
    if (src1_renamed !== 1'b1 || src1_rob_id !== 4'd9) begin
      n_fail++; $display("FAIL old_retire_no_bypass got r=%0b id=%0d want r=1 id=9", src1_renamed, src1_rob_id);
    end
    tick(); idle(); #1;
    n_checks++;
    if (src1_renamed !== 1'b1 || src1_rob_id !== 4'd9 || src1_reg_data !== 32'd0) begin
      n_fail++; $display("FAIL younger_survives got r=%0b id=%0d d=%h want r=1 id=9 d=0", src1_renamed, src1_rob_id, src1_reg_data);
    end
    do_retire(5'd6, 4'd9, 32'hBB); tick(); idle(); #1;
    n_checks++;
    if (src1_renamed !== 1'b0 || src1_rob_id !== 4'd0 || src1_reg_data !== 32'hBB) begin
      n_fail++; $display("FAIL younger_retired got r=%0b id=%0d d=%h want r=0 id=0 d=bb", src1_renamed, src1_rob_id, src1_reg_data);
    end
  endtask

  task automatic test_same_cycle();
    do_dispatch(5'd8, 4'd1); tick(); idle();
    src1_arf_id = 5'd8;
    do_dispatch(5'd8, 4'd4);
    do_retire(5'd8, 4'd1, 32'h77); #1;
    n_checks++;
    if (src1_renamed !== 1'b0 || src1_reg_data !== 32'h77) begin
      n_fail++; $display("FAIL same_cycle_pre_edge got r=%0b d=%h want r=0 d=77", src1_renamed, src1_reg_data);
    end
    tick(); idle(); #1;
    n_checks++;
    if (src1_renamed !== 1'b1 || src1_rob_id !== 4'd4) begin
      n_fail++; $display("FAIL rename_wins got r=%0b id=%0d want r=1 id=4", src1_renamed, src1_rob_id);
    end
    do_retire(5'd8, 4'd3, 32'h99); tick(); idle();
    do_retire(5'd8, 4'd4, 32'h99); tick(); idle(); #1;
    n_checks++;
    if (src1_renamed !== 1'b0 || src1_reg_data !== 32'h99) begin
      n_fail++; $display("FAIL x8_commit got r=%0b d=%h want r=0 d=99", src1_renamed, src1_reg_data);
    end
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 4; i++) begin
      do_dispatch(5'(i), 4'(9 + i)); tick();
    end
    idle();
    flush = 1;
    do_dispatch(5'd10, 4'd5);
    do_retire(5'd2, 4'd11, 32'h55);
    tick(); idle();
    for (int i = 1; i <= 4; i++) begin
      src1_arf_id = 5'(i); #1;
      n_checks++;
      if (src1_renamed !== 1'b0) begin
        n_fail++; $display("FAIL flush_x%0d got r=%0b want r=0", i, src1_renamed);
      end
    end
    src1_arf_id = 5'd2; src2_arf_id = 5'd10; #1;
    n_checks++;
    if (src1_reg_data !== 32'h55) begin
      n_fail++; $display("FAIL flush_retire_data got %h want 55", src1_reg_data);
    end
    n_checks++;
    if (src2_renamed !== 1'b0 || src2_reg_data !== 32'd0) begin
      n_fail++; $display("FAIL flush_drops_dispatch got r=%0b d=%h want r=0 d=0", src2_renamed, src2_reg_data);
    end
  endtask

  task automatic test_async_reset();
    do_dispatch(5'd12, 4'd3); tick();
    do_dispatch(5'd13, 4'd4); tick(); idle();
    src1_arf_id = 5'd12; src2_arf_id = 5'd13; #1;
    n_checks++;
    if (src1_renamed !== 1'b1 || src2_renamed !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_renamed got %0b%0b want 11", src1_renamed, src2_renamed);
    end
    rst_aL = 0; model_clear(); #1;
    n_checks++;
    if ({src1_renamed, src1_rob_id, src1_reg_data, src2_renamed, src2_rob_id, src2_reg_data} !== 74'd0) begin
      n_fail++; $display("FAIL async_reset_outputs got %h/%h want 0", {src1_renamed, src1_rob_id, src1_reg_data}, {src2_renamed, src2_rob_id, src2_reg_data});
    end
    src1_arf_id = 5'd14; src2_arf_id = 5'd5;
    do_dispatch(5'd14, 4'd6);
    do_retire(5'd5, 4'd0, 32'hFFFF);
    @(posedge clk); #1;
    n_checks++;
    if ({src1_renamed, src1_rob_id, src1_reg_data, src2_renamed, src2_rob_id, src2_reg_data} !== 74'd0) begin
      n_fail++; $display("FAIL inputs_ignored_in_reset got %h/%h want 0", {src1_renamed, src1_rob_id, src1_reg_data}, {src2_renamed, src2_rob_id, src2_reg_data});
    end
    idle();
    @(negedge clk); rst_aL = 1;
    tick(); #1;
    n_checks++;
    if (src2_renamed !== 1'b0 || src2_reg_data !== 32'd0) begin
      n_fail++; $display("FAIL post_reset_x5 got r=%0b d=%h want r=0 d=0", src2_renamed, src2_reg_data);
    end
  endtask

  task automatic test_random();
    logic [36:0] exp1, exp2;
    for (int c = 0; c < 400; c++) begin
      idle();
      retire = ($urandom_range(0, 1) == 1);
      retire_arf_id = 5'($urandom_range(0, 31));
      retire_reg_data = $urandom;
      retire_rob_id = ($urandom_range(0, 1) == 1) ? m_tag[retire_arf_id] : 4'($urandom_range(0, 15));
      dispatch_fire = ($urandom_range(0, 2) != 0);
      dispatch_dst_valid = ($urandom_range(0, 3) != 0);
      dispatch_dst_arf_id = 5'($urandom_range(0, 31));
      dispatch_rob_id = 4'($urandom_range(0, 15));
      flush = ($urandom_range(0, 24) == 0);
      src1_arf_id = ($urandom_range(0, 2) == 0) ? retire_arf_id : 5'($urandom_range(0, 31));
      src2_arf_id = 5'($urandom_range(0, 31));
      #1;
      exp1 = m_lookup(src1_arf_id);
      exp2 = m_lookup(src2_arf_id);
      n_checks++;
      if ({src1_renamed, src1_rob_id, src1_reg_data} !== exp1) begin
        n_fail++; $display("FAIL rand_src1 c=%0d id=%0d got %h want %h", c, src1_arf_id, {src1_renamed, src1_rob_id, src1_reg_data}, exp1);
      end
      n_checks++;
      if ({src2_renamed, src2_rob_id, src2_reg_data} !== exp2) begin
        n_fail++; $display("FAIL rand_src2 c=%0d id=%0d got %h want %h", c, src2_arf_id, {src2_renamed, src2_rob_id, src2_reg_data}, exp2);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    src1_arf_id = 0; src2_arf_id = 0;
    test_reset();
    test_rename_bypass();
    test_younger_survives();
    test_same_cycle();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
